apb_master_bridge: RTL and testbench

Single-outstanding APB master that converts a valid/ready request interface into APB SETUP/ACCESS transfers. It sits directly upstream of the APB slaves: it decodes the top address bits into a one-hot PSEL and drives the shared APB bus. It returns read data and an error flag on a one-cycle response pulse.

---
 rtl/apb_pkg.sv | 32 +++
 rtl/apb_psel_decode.sv | 24 ++
 rtl/apb_master_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg
// Shared definitions for the APB master bridge and its PSEL decoder:
//   - state_e        : bridge FSM states (IDLE, SETUP, ACCESS, RESP)
//   - SLV_IDX_W      : width of the slave-index field taken from the top address bits
//   - MISALIGN_MASK  : low address bits that must be zero for a legal word access
//   - req_t          : request bundle (write, addr, wdata, strb, prot) at the default
//                      bus widths, for upstream blocks that carry requests as one value
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int SLV_IDX_W = 2;

  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  localparam int REQ_ADDR_W = 16;
  localparam int REQ_DATA_W = 32;

  typedef struct packed {
    logic                    write;
    logic [REQ_ADDR_W-1:0]   addr;
    logic [REQ_DATA_W-1:0]   wdata;
    logic [REQ_DATA_W/8-1:0] strb;
    logic [2:0]              prot;
  } req_t;

endpackage

// File: rtl/apb_psel_decode.sv
// apb_psel_decode
// Combinational slave-index to one-hot PSEL decoder.
// Ports:
//   idx_i          in  SLV_IDX_W   slave index (top address bits)
//   psel_o         out NUM_SLAVES  one-hot select, all zero when out of range
//   out_of_range_o out 1           index has no slave behind it
module apb_psel_decode
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES = 4
) (
  input  logic [SLV_IDX_W-1:0]  idx_i,
  output logic [NUM_SLAVES-1:0] psel_o,
  output logic                  out_of_range_o
);

  always_comb begin
    out_of_range_o = (int'(idx_i) >= NUM_SLAVES);
    for (int i = 0; i < NUM_SLAVES; i++) begin
      psel_o[i] = (int'(idx_i) == i);
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Single-outstanding APB master: turns a valid/ready request into an APB
// SETUP/ACCESS transfer and returns a one-cycle response pulse. All outputs
// are registered; PRESETn (asynchronous, active-low) clears every output.
// Optional feature: define APB_MASTER_TIMEOUT_EN to bound ACCESS at
// TIMEOUT_CYCLES wait cycles (error response on expiry).
// Ports:
//   PCLK, PRESETn                                  clock / async active-low reset
//   req_valid_i/req_ready_o, req_write_i, req_addr_i,
//   req_wdata_i, req_strb_i, req_prot_i            request channel
//   rsp_valid_o, rsp_rdata_o, rsp_err_o            response pulse
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA,
//   PSTRB, PPROT                                   APB master outputs
//   PREADY, PSLVERR, PRDATA                        APB slave returns (pre-muxed)
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [NUM_SLAVES-1:0]   PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic [DATA_WIDTH-1:0]   PRDATA
);

  localparam int STRB_W = DATA_WIDTH / 8;

  state_e state_q, state_d;

  logic                  req_ready_q,  req_ready_d;
  logic                  rsp_valid_q,  rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,  rsp_rdata_d;
  logic                  rsp_err_q,    rsp_err_d;
  logic [NUM_SLAVES-1:0] psel_q,       psel_d;
  logic                  penable_q,    penable_d;
  logic                  pwrite_q,     pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,      paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,     pwdata_d;
  logic [STRB_W-1:0]     pstrb_q,      pstrb_d;
  logic [2:0]            pprot_q,      pprot_d;

  logic                  accept;
  logic                  bad_req;
  logic                  timeout;
  logic [NUM_SLAVES-1:0] dec_psel;
  logic                  dec_oor;

  apb_psel_decode #(
    .NUM_SLAVES (NUM_SLAVES)
  ) u_psel_decode (
    .idx_i          (req_addr_i[ADDR_WIDTH-1 -: SLV_IDX_W]),
    .psel_o         (dec_psel),
    .out_of_range_o (dec_oor)
  );

  // req_ready_q is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept  = req_valid_i && req_ready_q;
  // Unreachable slaves are rejected the same way as misaligned addresses.
  assign bad_req = (|(req_addr_i[1:0] & MISALIGN_MASK)) || dec_oor;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Counts completed ACCESS cycles without PREADY; the TIMEOUT_CYCLES-th
  // such cycle ends the transfer.
  assign timeout = (state_q == ST_ACCESS) && !PREADY &&
                   (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_SETUP) begin
      wait_cnt_d = '0;
    end else if ((state_q == ST_ACCESS) && !PREADY && !timeout) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = bad_req ? ST_RESP : ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (PREADY || timeout) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    rsp_valid_d = (state_d == ST_RESP);
    req_ready_d = (state_d == ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bad_req) begin
            rsp_err_d = 1'b1;
          end else begin
            psel_d   = dec_psel;
            pwrite_d = req_write_i;
            paddr_d  = req_addr_i;
            pwdata_d = req_wdata_i;
            pstrb_d  = req_write_i ? req_strb_i : '0;
            pprot_d  = req_prot_i;
          end
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
        end else if (timeout) begin
          psel_d    = '0;
          penable_d = 1'b0;
          rsp_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
    end else begin
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign PPROT       = pprot_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
// Directed and randomized transactions against apb_master_bridge, checked
// against a transaction-level expectation (latency, select, response) derived
// from the address, wait count and slave response of each request.
module tb_apb_master_bridge;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int TO = 16;

  logic          PCLK      = 1'b0;
  logic          PRESETn   = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW/8-1:0] req_strb = '0;
  logic [2:0]    req_prot  = '0;
  logic          PREADY    = 1'b0;
  logic          PSLVERR   = 1'b0;
  logic [DW-1:0] PRDATA    = '0;

  logic            req_ready;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [NS-1:0]   PSEL;
  logic            PENABLE;
  logic            PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic [DW/8-1:0] PSTRB;
  logic [2:0]      PPROT;

  int errors = 0;
  int checks = 0;

  apb_master_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .NUM_SLAVES     (NS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_strb_i  (req_strb),
    .req_prot_i  (req_prot),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PPROT       (PPROT),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .PRDATA      (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {req_ready, rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE, PWRITE,
              PADDR, PWDATA, PSTRB, PPROT}, '0);
  endtask

  // One request from issue to response. waits<0 means PREADY never rises.
  task automatic run_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW/8-1:0] st, input logic [2:0] pr,
                         input int waits, input logic serr, input logic [DW-1:0] sdata);
    logic            bad;
    logic            stuck;
    logic [NS-1:0]   exp_psel;
    int              exp_lat;
    int              last_bus;
    logic            exp_err;
    logic [DW-1:0]   exp_rdata;
    logic [DW/8-1:0] exp_strb;
    bit              seen;
    stuck     = (waits < 0);
    bad       = (a[1:0] != 2'b00) || (int'(a[AW-1:AW-2]) >= NS);
    exp_psel  = bad ? '0 : NS'(1) << a[AW-1:AW-2];
    exp_lat   = bad ? 1 : (stuck ? 2 + TO : 3 + waits);
    last_bus  = exp_lat - 1;
    exp_err   = bad || stuck || serr;
    exp_rdata = (bad || stuck || w || serr) ? '0 : sdata;
    exp_strb  = w ? st : '0;
    seen      = 0;

    @(negedge PCLK);
    chk("ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    req_strb  = st;
    req_prot  = pr;
    PREADY    = 1'b0;

    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge PCLK);
      if (cyc == 1) begin
        // scramble the request lines so only the latched copy can be on the bus
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = ~a;
        req_wdata = ~wd;
        req_strb  = ~st;
        req_prot  = ~pr;
      end
      if (rsp_valid) begin
        chk("rsp_latency", 128'(cyc), 128'(exp_lat));
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_bus_released", {PSEL, PENABLE}, '0);
        chk("rsp_ready_low", req_ready, 1'b0);
        seen = 1;
        break;
      end
      if (bad) begin
        chk("bad_no_psel", PSEL, '0);
      end else if (cyc <= last_bus) begin
        chk("psel", PSEL, exp_psel);
        chk("penable", PENABLE, (cyc >= 2));
        chk("bus_fields", {PWRITE, PADDR, PWDATA, PSTRB, PPROT},
            {w, a, wd, exp_strb, pr});
        chk("ready_busy", req_ready, 1'b0);
      end
      PREADY  = !stuck && (cyc == 2 + waits);
      PSLVERR = PREADY ? serr : 1'($urandom);
      PRDATA  = PREADY ? sdata : $urandom;
    end
    if (!seen) chk("rsp_seen", 1'b0, 1'b1);

    @(negedge PCLK);
    PREADY = 1'b0;
    chk("rsp_one_cycle", rsp_valid, 1'b0);
    chk("ready_after_rsp", req_ready, 1'b1);
  endtask

  initial begin
    // reset state
    #12;
    chk_all_zero("reset_outputs");
    @(negedge PCLK);
    PRESETn = 1'b1;
    chk_all_zero("reset_release_outputs");
    @(negedge PCLK);
    chk("ready_after_reset", req_ready, 1'b1);

    // zero-wait write to slave 1
    run_txn(1'b1, 16'h4010, 32'hDEADBEEF, 4'hF, 3'b010, 0, 1'b0, 32'h0);
    // read with three wait states
    run_txn(1'b0, 16'h0008, 32'hAAAA5555, 4'hC, 3'b001, 3, 1'b0, 32'h12345678);
    // slave error on a read
    run_txn(1'b0, 16'hC020, 32'h0, 4'h0, 3'b000, 1, 1'b1, 32'hCAFEF00D);
    // misaligned
    run_txn(1'b0, 16'h0006, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h0);
    // partial-strobe write to slave 2
    run_txn(1'b1, 16'h8FFC, 32'h01020304, 4'b0101, 3'b111, 2, 1'b0, 32'h0);

    // reset pulsed during ACCESS
    @(negedge PCLK);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h8004;
    req_wdata = '0; req_strb = '0; req_prot = 3'b101; PREADY = 1'b0;
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    chk("pre_abort_access", {PSEL, PENABLE}, {4'b0100, 1'b1});
    #2 PRESETn = 1'b0;
    #1 chk_all_zero("abort_immediate");
    @(negedge PCLK);
    chk_all_zero("abort_held");
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("abort_no_rsp", rsp_valid, 1'b0);
    chk("abort_ready", req_ready, 1'b1);
    run_txn(1'b0, 16'h4000, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h0BADC0DE);

`ifdef APB_MASTER_TIMEOUT_EN
    run_txn(1'b0, 16'h4044, 32'h0, 4'h0, 3'b000, -1, 1'b0, 32'h0);
`endif

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] ra;
      ra = AW'($urandom);
      if ($urandom_range(3) != 0) ra[1:0] = 2'b00;
      run_txn(1'($urandom), ra, $urandom, 4'($urandom), 3'($urandom),
              int'($urandom_range(4)), ($urandom_range(3) == 0), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
